// File: rtl/stream_packer_tx_pkg.sv
// Shared types and helpers for the stream_packer_tx transmit packer.
// Holds the default idle pattern, the ratio/pointer-width helpers and the lane counter type.
package stream_packer_tx_pkg;

  localparam logic [63:0] DEFAULT_IDLE_PATTERN = 64'h0;
  localparam int          LANE_CNT_W           = 8;

  typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

  function automatic int calc_ratio(input int data_width, input int in_width);
    return data_width / in_width;
  endfunction

  function automatic int calc_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_packer_tx_fifo.sv
// Synchronous word FIFO for stream_packer_tx with wrap-bit pointers and a registered level.
// Exposes the entry behind the head so the top can preload its output register on a pop.
module stream_packer_tx_fifo
  import stream_packer_tx_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 4,
  parameter int PW    = calc_ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] peek_next,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] level
);

  localparam int AW = PW - 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] level_r;
  logic [AW-1:0] rd_next_idx_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Same index with differing wrap bits means every slot is occupied.
  assign full          = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty         = (wr_ptr_r == rd_ptr_r);
  assign push_ok_s     = push & ~full;
  assign pop_ok_s      = pop & ~empty;
  assign rd_next_idx_s = rd_ptr_r[AW-1:0] + AW'(1);
  assign peek_next     = mem[rd_next_idx_s];
  assign level         = level_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + PW'(1);
        2'b01:   level_r <= level_r - PW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) mem[wr_ptr_r[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/stream_packer_tx.sv
// Packs RATIO narrow beats LSB-first into DATA_WIDTH words, buffers them and streams them out.
// Optional zero-padded early flush is enabled by defining STREAM_PACKER_TX_FLUSH_EN.
module stream_packer_tx
  import stream_packer_tx_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    IN_WIDTH     = 16,
  parameter int                    FIFO_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = DATA_WIDTH'(DEFAULT_IDLE_PATTERN)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_WIDTH-1:0]             in_data,
  output logic [DATA_WIDTH-1:0]           data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fill_level
`ifdef STREAM_PACKER_TX_FLUSH_EN
  ,
  input  logic                            flush
`endif
);

  localparam int RATIO = calc_ratio(DATA_WIDTH, IN_WIDTH);
  localparam int PTR_W = calc_ptr_w(FIFO_DEPTH);

  if ((DATA_WIDTH % IN_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("stream_packer_tx: DATA_WIDTH must be a multiple of IN_WIDTH with RATIO >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_packer_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  if (RATIO > (2 ** LANE_CNT_W)) begin : g_bad_lane_w
    $error("stream_packer_tx: RATIO exceeds lane counter range");
  end

  lane_cnt_t             lane_cnt_r;
  logic [DATA_WIDTH-1:0] word_r;
  logic [DATA_WIDTH-1:0] word_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] data_nxt_s;
  logic [DATA_WIDTH-1:0] peek_next_s;
  logic                  out_valid_r;
  logic                  valid_nxt_s;
  logic                  full_s;
  logic                  empty_s;
  logic [PTR_W-1:0]      level_s;
  logic                  in_ready_s;
  logic                  beat_acc_s;
  logic                  last_lane_s;
  logic                  flush_push_s;
  logic                  flush_pend_s;
  logic                  push_s;
  logic                  pop_s;

`ifdef STREAM_PACKER_TX_FLUSH_EN
  logic flush_pend_r;
  logic flush_act_s;

  // A flush only means something with a partial word; while full it waits for room.
  assign flush_act_s  = (flush | flush_pend_r) & (lane_cnt_r != lane_cnt_t'(0));
  assign flush_push_s = flush_act_s & ~full_s;
  assign flush_pend_s = flush_pend_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flush_pend_r <= 1'b0;
    else       flush_pend_r <= flush_act_s & full_s;
  end
`else
  assign flush_push_s = 1'b0;
  assign flush_pend_s = 1'b0;
`endif

  assign in_ready_s  = ~full_s & ~reset & ~flush_pend_s;
  assign beat_acc_s  = in_valid & in_ready_s;
  assign last_lane_s = (lane_cnt_r == lane_cnt_t'(RATIO - 1));
  assign push_s      = (beat_acc_s & last_lane_s) | flush_push_s;
  assign pop_s       = out_valid_r & out_ready;

  // Insert the current beat into its lane; unfilled lanes are already zero.
  always_comb begin
    word_s = word_r;
    if (beat_acc_s) begin
      word_s[lane_cnt_r*IN_WIDTH +: IN_WIDTH] = in_data;
    end else begin
      word_s = word_r;
    end
  end

  // word_r is cleared on every push so padding never picks up stale lanes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_cnt_r <= '0;
      word_r     <= '0;
    end else if (push_s) begin
      lane_cnt_r <= '0;
      word_r     <= '0;
    end else if (beat_acc_s) begin
      lane_cnt_r <= lane_cnt_r + lane_cnt_t'(1);
      word_r     <= word_s;
    end
  end

  stream_packer_tx_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .PW    (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .wr_data   (word_s),
    .pop       (pop_s),
    .peek_next (peek_next_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level_s)
  );

  // The output register tracks what the FIFO head will be after this edge.
  always_comb begin
    data_nxt_s  = data_r;
    valid_nxt_s = out_valid_r;
    case ({push_s, pop_s})
      2'b01: begin
        if (level_s == PTR_W'(1)) begin
          data_nxt_s  = IDLE_PATTERN;
          valid_nxt_s = 1'b0;
        end else begin
          data_nxt_s  = peek_next_s;
          valid_nxt_s = 1'b1;
        end
      end
      2'b11: begin
        valid_nxt_s = 1'b1;
        if (level_s == PTR_W'(1)) data_nxt_s = word_s;
        else                      data_nxt_s = peek_next_s;
      end
      2'b10: begin
        valid_nxt_s = 1'b1;
        if (empty_s) data_nxt_s = word_s;
        else         data_nxt_s = data_r;
      end
      default: begin
        data_nxt_s  = data_r;
        valid_nxt_s = out_valid_r;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r      <= IDLE_PATTERN;
      out_valid_r <= 1'b0;
    end else begin
      data_r      <= data_nxt_s;
      out_valid_r <= valid_nxt_s;
    end
  end

  assign data       = data_r;
  assign out_valid  = out_valid_r;
  assign in_ready   = in_ready_s;
  assign fill_level = level_s;

endmodule

// File: doc/stream_packer_tx.md
Name: stream_packer_tx

Overview:
- Transmit-side counterpart to my_module.
- Accepts narrow IN_WIDTH beats over a valid/ready handshake and packs RATIO = DATA_WIDTH/IN_WIDTH beats into one DATA_WIDTH word.
- Buffers complete words in a small FIFO.
- Drives the data signal bound into a my_interface instance (DATA_WIDTH=64), qualified by out_valid/out_ready.

Parameters:
- DATA_WIDTH, 64, output word width; must equal the my_interface DATA_WIDTH.
- IN_WIDTH, 16, input beat width; DATA_WIDTH % IN_WIDTH == 0 and RATIO >= 2, checked by an elaboration assertion.
- FIFO_DEPTH, 4, words buffered; power of 2, >= 2.
- IDLE_PATTERN, 64'h0, value driven on data while out_valid=0.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_data  input  IN_WIDTH  input beat
- data  output  DATA_WIDTH  stream word; connects to my_interface data
- out_valid  output  1  data holds a valid word
- out_ready  input  1  consumer takes the word when out_valid & out_ready
- fill_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: one clock domain (clk); reset is asynchronous and active-high.
- Reset values: out_valid=0, data=IDLE_PATTERN, fill_level=0, lane counter=0, FIFO pointers=0.
- in_ready is forced 0 while reset is high.
- Reset mid-operation discards the partial word and all FIFO contents. No stale lanes survive.
- Packing:
  - Beats fill lanes LSB first: beat k goes to word[k*IN_WIDTH +: IN_WIDTH].
  - lane_cnt counts 0..RATIO-1 and wraps to 0 on the final lane.
- Push: the handshake on lane RATIO-1 writes the assembled word into the FIFO in the same cycle.
- in_ready = ~full & ~reset, where full means fill_level == FIFO_DEPTH. It is held low for all lanes when full, not only the final lane.
- Pop: data and out_valid are driven from a registered FIFO head.
  - out_valid=1 whenever fill_level > 0.
  - The handshake pops; the next word appears on the following cycle.
  - data holds its value while out_valid & ~out_ready.
  - data returns to IDLE_PATTERN when the FIFO empties.
- Latency: final lane accepted at cycle N -> out_valid=1 with that word at cycle N+1, when the FIFO was empty.
- Simultaneous events:
  - Push and pop in the same cycle while not full: fill_level unchanged.
  - When full, a push is blocked even if a pop occurs that cycle; there is no pass-through. The beat is accepted the next cycle.
- Overflow and underflow are impossible by construction. Elaboration assertions flag any violation.
- fill_level is registered and counts only completed words, never partial lanes.
- Pointers are $clog2(FIFO_DEPTH)+1 bits with a wrap bit. Full/empty is derived from the pointer MSB compare.

Optional Feature:
- Macro: STREAM_PACKER_TX_FLUSH_EN.
- With the macro:
  - Adds input port flush (1 bit).
  - When flush=1 and lane_cnt>0, the remaining lanes are zero-padded and the word is pushed that cycle; lane_cnt then returns to 0.
  - If a beat handshake coincides with flush, the beat occupies its lane first, then padding is applied.
  - flush is ignored when lane_cnt==0.
  - When full, the flush is held pending until space exists; in_ready stays low while it is pending.
- Without the macro: no flush port; words complete only on RATIO beats.

Decomposition:
- Package stream_packer_tx_pkg holds:
  - the default IDLE_PATTERN constant;
  - a function computing RATIO and pointer width;
  - a typedef for the lane counter.
- Sub-module stream_packer_tx_fifo: synchronous FIFO with push/pop/full/empty/level. The packing logic and output register stay in the top level.

Test Plan (IN_WIDTH=16, DATA_WIDTH=64, FIFO_DEPTH=4 unless stated):
1. Beats 16'h1111, 2222, 3333, 4444 with out_ready=1 -> the cycle after the 4th accept, data=64'h4444_3333_2222_1111 with out_valid=1 for exactly 1 cycle; then data=IDLE_PATTERN.
2. out_ready=0, 16 beats pushed -> fill_level=4 and in_ready=0; the 17th beat stalls. Then out_ready=1 -> 4 words pop in order and in_ready returns to 1 one cycle after the first pop.
3. No input for 20 cycles after reset -> data=64'h0, out_valid=0, in_ready=1.
4. Reset asserted asynchronously mid-cycle after 2 beats (AAAA, BBBB) -> outputs reset immediately. After release, beats 1,2,3,4 yield 64'h0004_0003_0002_0001.
5. fill_level=4, out_ready=1, in_valid=1 -> pop occurs and the beat is refused that cycle, accepted next cycle; ordering is preserved.
6. With STREAM_PACKER_TX_FLUSH_EN: beats AAAA, BBBB then flush -> 64'h0000_0000_BBBB_AAAA. A flush with lane_cnt=0 produces no word.
